board_seed_loader: RTL
======================

Name: board_seed_loader

Overview:
Upstream stage of Game_of_Life_machine. It debounces the board buttons and lets the user edit a 16x16 seed board one row at a time from the 16 switches. It then hands the finished 256-bit seed to the machine over a valid/ready handshake. The board is frozen while a commit is pending.

Parameters:
DEBOUNCE_CYCLES, 20'd1000000, consecutive stable synchronized samples required before a button level change is accepted (must be >= 2)
ROWS, 16, board rows (fixed; cursor width 4)
COLS, 16, board columns (fixed; equals switch count)

Ports:
ClkPort  in  1  system clock; all logic is on the rising edge
Reset_n  in  1  asynchronous, active-low reset
BtnL  in  1  raw button: cursor row down
BtnR  in  1  raw button: cursor row up
BtnU  in  1  raw button: write switches into the cursor row
BtnD  in  1  raw button: commit the seed to the machine
BtnC  in  1  raw button: clear the whole board
Sw  in  16  raw switch row value; Sw[c] maps to column c
seed_ready_i  in  1  machine can accept a seed
seed_board_o  out  256  seed board; cell (r,c) is bit r*16+c
seed_valid_o  out  1  seed_board_o is offered to the machine
cursor_row_o  out  4  currently selected row
editing_o  out  1  1 in state EDIT, 0 in state COMMIT

Behaviour:
- Reset (asynchronous, immediate, including mid-commit):
  - seed_board_o=0, cursor_row_o=0, seed_valid_o=0, editing_o=1, state=EDIT.
  - All synchronizer and debounce state is cleared to 0.
- Button conditioning, per button, identical logic:
  - 2-FF synchronizer, then a debounce counter.
  - The counter resets whenever the synchronized sample differs from the debounced level.
  - When the difference has persisted for DEBOUNCE_CYCLES consecutive cycles, the level flips and the counter clears.
  - A debounced 0->1 transition produces a one-cycle press pulse.
  - Latency: raw input held high continuously -> pulse asserted in cycle DEBOUNCE_CYCLES+2 after the first high sample.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
  - Holding a button produces exactly one pulse. Release must also debounce before the next press can pulse.
- Sw is 2-FF synchronized only (no debounce). The write uses the synchronized value in the pulse cycle.
- State EDIT. At most one action per cycle, priority C > U > D > R > L; a lower-priority pulse in the same cycle is dropped:
  - C: seed_board_o <= 0; cursor unchanged.
  - U: seed_board_o[cursor*16 +: 16] <= Sw_sync; other rows unchanged.
  - D: go to COMMIT; seed_valid_o=1 and editing_o=0 from the next cycle.
  - R: cursor <= cursor+1, wrapping 15->0.
  - L: cursor <= cursor-1, wrapping 0->15.
  - All updates are visible the cycle after the pulse.
- State COMMIT:
  - seed_valid_o=1; seed_board_o and cursor are held stable.
  - All button pulses are ignored and discarded, not queued.
  - Transfer occurs in the cycle where seed_valid_o && seed_ready_i. The next cycle returns to EDIT with seed_valid_o=0 and editing_o=1.
  - The board contents are retained after the transfer (not cleared).
  - seed_ready_i high in the D pulse cycle itself has no effect; the transfer can occur no earlier than the first COMMIT cycle.
  - seed_ready_i low indefinitely means COMMIT is held indefinitely.
- seed_valid_o never deasserts without a transfer, except on reset.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4.)
1. Debounce: BtnR high 3 cycles then low -> cursor_row_o stays 0. BtnR high 10 cycles -> exactly one increment to 1, with the pulse in cycle 6 after the first high sample.
2. Cursor wrap: from reset, press BtnL once -> cursor_row_o=15. Then press BtnR once -> 0. Press BtnR 17 times -> 1.
3. Row write: Sw=16'hA5C3; press BtnR 3 times then BtnU -> seed_board_o[63:48]=16'hA5C3, all other bits 0. Then press BtnC -> seed_board_o=0, cursor_row_o=3.
4. Commit handshake: write row 0=16'hFFFF; press BtnD with seed_ready_i=0 -> seed_valid_o=1, editing_o=0, and it holds for 20 cycles. Press BtnU/BtnC meanwhile -> board unchanged. Raise seed_ready_i for 1 cycle -> seed_valid_o=0 the next cycle; board still has row 0=16'hFFFF.
5. Simultaneous pulses: BtnU and BtnC rise in the same cycle -> board all 0 (clear wins). BtnR and BtnL together -> cursor +1.
6. Reset mid-commit: in COMMIT with board non-zero, pulse Reset_n low between clock edges -> seed_valid_o=0, seed_board_o=0, cursor_row_o=0 immediately. After release, buttons function normally.

Source files
------------

// File: rtl/board_seed_loader.sv
// Seed-board editor for the Game of Life machine: debounced buttons edit a 16x16
// board row by row from the switches, then offer it over a valid/ready handshake.
module board_seed_loader #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter int          ROWS            = 16,
    parameter int          COLS            = 16
) (
    input  logic                 ClkPort,
    input  logic                 Reset_n,
    input  logic                 BtnL,
    input  logic                 BtnR,
    input  logic                 BtnU,
    input  logic                 BtnD,
    input  logic                 BtnC,
    input  logic [COLS-1:0]      Sw,
    input  logic                 seed_ready_i,
    output logic [ROWS*COLS-1:0] seed_board_o,
    output logic                 seed_valid_o,
    output logic [3:0]           cursor_row_o,
    output logic                 editing_o
);

    // state     | meaning
    // ST_EDIT   | buttons edit the board / move the cursor
    // ST_COMMIT | board offered to the machine, frozen until accepted
    localparam logic [0:0] ST_EDIT   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    localparam int B_L  = 0;
    localparam int B_R  = 1;
    localparam int B_U  = 2;
    localparam int B_D  = 3;
    localparam int B_C  = 4;
    localparam int NBTN = 5;

    localparam logic [19:0] DB_LAST = DEBOUNCE_CYCLES - 20'd1;

    logic [NBTN-1:0]        btn_raw;
    logic [NBTN-1:0]        sync1_q, sync2_q;
    logic [NBTN-1:0]        level_q, level_d;
    logic [NBTN-1:0]        pulse_q, pulse_d;
    logic [NBTN-1:0][19:0]  cnt_q, cnt_d;

    logic [COLS-1:0]        sw_sync1_q, sw_sync2_q;

    logic [0:0]             state_q, state_d;
    logic [ROWS*COLS-1:0]   board_q, board_d;
    logic [3:0]             cursor_q, cursor_d;

    assign btn_raw = {BtnC, BtnD, BtnU, BtnR, BtnL};

    // Level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        for (int b = 0; b < NBTN; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != level_q[b]) begin
                if (cnt_q[b] == DB_LAST) begin
                    level_d[b] = ~level_q[b];
                    pulse_d[b] = ~level_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            pulse_q    <= '0;
            cnt_q      <= '0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            cnt_q      <= cnt_d;
            sw_sync1_q <= Sw;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // One action per cycle, priority C > U > D > R > L; pulses in COMMIT are dropped.
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        cursor_d = cursor_q;
        case (state_q)
            ST_EDIT: begin
                if (pulse_q[B_C]) begin
                    board_d = '0;
                end else if (pulse_q[B_U]) begin
                    board_d[{cursor_q, 4'b0000} +: COLS] = sw_sync2_q;
                end else if (pulse_q[B_D]) begin
                    state_d = ST_COMMIT;
                end else if (pulse_q[B_R]) begin
                    cursor_d = cursor_q + 4'd1;
                end else if (pulse_q[B_L]) begin
                    cursor_d = cursor_q - 4'd1;
                end
            end
            ST_COMMIT: begin
                if (seed_ready_i) begin
                    state_d = ST_EDIT;
                end
            end
            default: state_d = ST_EDIT;
        endcase
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_EDIT;
            board_q  <= '0;
            cursor_q <= '0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            cursor_q <= cursor_d;
        end
    end

    assign seed_board_o = board_q;
    assign cursor_row_o = cursor_q;
    assign seed_valid_o = (state_q == ST_COMMIT);
    assign editing_o    = (state_q == ST_EDIT);

endmodule
